// File: rtl/bpf_queue.sv
// bpf_queue -- branch-resolution feedback unit.
//
// Resolves up to NCH branches per cycle. Channel 0 is the oldest. For each
// channel it computes the target, the taken flag and whether the fetch
// prediction was wrong. The oldest mispredict drives a registered one-cycle
// front-end redirect. Resolved branches are queued in a DEPTH-entry FIFO
// and handed to the BPU one per cycle through a valid/ready handshake.
//
// Optional feature: define BPF_BYPASS_EN so that an empty FIFO presents the
// oldest accepted entry combinationally. That gives zero-latency updates.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_i             backend flush; drops this cycle's inputs
//   in_valid_i[NCH]     channel carries a branch-unit instruction
//   in_ready_o          all NCH channels can be accepted this cycle
//   pc_i/rj_i/rd_i      per-channel pc and operand values
//   decode_i            decode info (inst[25:0], cmp_type, branch_link)
//   br_type_i           INVALID / IMMEDIATE / INDIRECT / CONDITION
//   predict_i           fetch-time prediction (npc, lphr, lphr_index)
//   redirect_valid_o    one-cycle redirect pulse
//   redirect_pc_o       corrected fetch pc
//   upd_valid_o         update entry valid
//   upd_ready_i         BPU accepts the update entry
//   update_o            update entry
//
// Instruction field layout (LoongArch):
//   rd_idx = inst[4:0]
//   rj_idx = inst[9:5]
//   offs16 = inst[25:10]
//   offs26 = {inst[9:0], inst[25:10]}

package bpf_pkg;
  typedef enum logic [1:0] {
    INVALID   = 2'd0,
    IMMEDIATE = 2'd1,
    INDIRECT  = 2'd2,
    CONDITION = 2'd3
  } branch_type_t;

  typedef enum logic [3:0] {
    CMP_NONE = 4'd0,
    EQL      = 4'd1,
    NEQ      = 4'd2,
    LSS      = 4'd3,
    GER      = 4'd4,
    LEQ      = 4'd5,
    GEQ      = 4'd6,
    LTU      = 4'd7,
    GEU      = 4'd8
  } cmp_type_t;

  typedef enum logic [1:0] {
    PC_RELATIVE = 2'd0,
    ABSOLUTE    = 2'd1,
    CALL        = 2'd2,
    RETURN      = 2'd3
  } bpu_br_type_t;

  typedef struct packed {
    logic [25:0] inst25_0;
  } decode_general_t;

  typedef struct packed {
    cmp_type_t cmp_type;
    logic      branch_link;
  } decode_ex_t;

  typedef struct packed {
    decode_general_t general;
    decode_ex_t      ex;
  } decode_info_t;

  typedef struct packed {
    logic [29:0] npc;
    logic [3:0]  lphr;
    logic [9:0]  lphr_index;
  } bpu_predict_t;

  typedef struct packed {
    logic         flush;
    logic         br_taken;
    logic         btb_update;
    logic         bht_update;
    logic         lpht_update;
    logic [29:0]  pc;
    logic [29:0]  br_target;
    bpu_br_type_t br_type;
    logic [3:0]   lphr;
    logic [9:0]   lphr_index;
  } bpu_update_t;
endpackage

module bpf_queue
  import bpf_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic         [NCH-1:0]        in_valid_i,
  output logic                          in_ready_o,
  input  logic         [NCH-1:0][31:0]  pc_i,
  input  logic         [NCH-1:0][31:0]  rj_i,
  input  logic         [NCH-1:0][31:0]  rd_i,
  input  decode_info_t [NCH-1:0]        decode_i,
  input  branch_type_t [NCH-1:0]        br_type_i,
  input  bpu_predict_t [NCH-1:0]        predict_i,
  output logic                          redirect_valid_o,
  output logic         [31:0]           redirect_pc_o,
  output logic                          upd_valid_o,
  input  logic                          upd_ready_i,
  output bpu_update_t                   update_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic        [AW-1:0]         head;
  logic        [AW-1:0]         tail;
  logic        [CW-1:0]         count;
  bpu_update_t [DEPTH-1:0]      mem;

  logic                         accept;
  logic        [NCH-1:0][31:0]  target;
  logic        [NCH-1:0]        taken;
  logic        [NCH-1:0]        mp;
  logic        [NCH-1:0]        elig;
  logic        [NCH-1:0]        push;
  bpu_update_t [NCH-1:0]        ent;
  logic        [NCH-1:0][AW-1:0] widx;
  logic        [CW-1:0]         push_cnt;
  logic                         any_mp;
  logic        [31:0]           redir_tgt;
  logic                         fifo_pop;

  logic        [25:0]           inst;
  logic        [15:0]           offs16;
  logic        [25:0]           offs26;
  logic        [31:0]           imm16;
  logic        [31:0]           imm26;
  bpu_br_type_t                 cls;

  // Readiness depends on the registered count only, never on in_valid_i.
  assign in_ready_o = (CW'(DEPTH) - count) >= CW'(NCH);
  assign accept     = (|in_valid_i) && in_ready_o && !flush_i;

  // Per-channel resolution and squash of channels younger than the oldest
  // mispredict.
  always_comb begin
    target    = '0;
    taken     = '0;
    mp        = '0;
    elig      = '0;
    ent       = '0;
    any_mp    = 1'b0;
    redir_tgt = '0;
    inst      = '0;
    offs16    = '0;
    offs26    = '0;
    imm16     = '0;
    imm26     = '0;
    cls       = PC_RELATIVE;

    for (int unsigned c = 0; c < NCH; c++) begin
      inst   = decode_i[c].general.inst25_0;
      offs16 = inst[25:10];
      offs26 = {inst[9:0], inst[25:10]};
      imm16  = {{14{offs16[15]}}, offs16, 2'b00};
      imm26  = {{4{offs26[25]}}, offs26, 2'b00};

      case (br_type_i[c])
        IMMEDIATE: target[c] = pc_i[c] + imm26;
        INDIRECT:  target[c] = rj_i[c] + imm16;
        CONDITION: target[c] = pc_i[c] + imm16;
        default:   target[c] = pc_i[c] + 32'd4;
      endcase

      if (br_type_i[c] == CONDITION) begin
        case (decode_i[c].ex.cmp_type)
          EQL:     taken[c] = (rj_i[c] == rd_i[c]);
          NEQ:     taken[c] = (rj_i[c] != rd_i[c]);
          LSS:     taken[c] = ($signed(rj_i[c]) <  $signed(rd_i[c]));
          GER:     taken[c] = ($signed(rj_i[c]) >  $signed(rd_i[c]));
          LEQ:     taken[c] = ($signed(rj_i[c]) <= $signed(rd_i[c]));
          GEQ:     taken[c] = ($signed(rj_i[c]) >= $signed(rd_i[c]));
          LTU:     taken[c] = (rj_i[c] <  rd_i[c]);
          GEU:     taken[c] = (rj_i[c] >= rd_i[c]);
          default: taken[c] = 1'b0;
        endcase
      end else begin
        taken[c] = (br_type_i[c] != INVALID);
      end

      if (((br_type_i[c] == INDIRECT) && (inst[4:0] == 5'd1)) ||
          decode_i[c].ex.branch_link)
        cls = CALL;
      else if ((br_type_i[c] == INDIRECT) && (inst[9:5] == 5'd1) &&
               (offs16 == 16'd0))
        cls = RETURN;
      else if ((br_type_i[c] == IMMEDIATE) || (br_type_i[c] == INDIRECT))
        cls = ABSOLUTE;
      else
        cls = PC_RELATIVE;

      mp[c] = accept && in_valid_i[c] && (br_type_i[c] != INVALID) &&
              (predict_i[c].npc != target[c][31:2]);
      // any_mp here still reflects older channels only, so the
      // mispredicting channel itself is kept and younger ones are squashed.
      elig[c] = accept && in_valid_i[c] && (br_type_i[c] != INVALID) &&
                !any_mp;
      if (mp[c] && !any_mp) begin
        any_mp    = 1'b1;
        redir_tgt = target[c];
      end

      ent[c].flush       = mp[c];
      ent[c].br_taken    = taken[c];
      ent[c].btb_update  = mp[c];
      ent[c].bht_update  = 1'b1;
      ent[c].lpht_update = 1'b1;
      ent[c].pc          = pc_i[c][31:2];
      ent[c].br_target   = target[c][31:2];
      ent[c].br_type     = cls;
      ent[c].lphr        = predict_i[c].lphr;
      ent[c].lphr_index  = predict_i[c].lphr_index;
    end
  end

`ifdef BPF_BYPASS_EN
  logic        [NCH-1:0] byp_sel;
  bpu_update_t           byp_ent;
  logic                  byp_found;
`endif

  // Output selection, pop and compaction of pushed channels into
  // consecutive FIFO slots.
  always_comb begin
    push        = elig;
    upd_valid_o = (count != '0);
    update_o    = mem[head];
    fifo_pop    = 1'b0;
`ifdef BPF_BYPASS_EN
    byp_sel   = '0;
    byp_ent   = '0;
    byp_found = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (elig[c] && !byp_found) begin
        byp_found  = 1'b1;
        byp_sel[c] = 1'b1;
        byp_ent    = ent[c];
      end
    end
    // Empty FIFO: present the oldest eligible channel directly. If the BPU
    // takes it now, it is not written to the FIFO.
    if ((count == '0) && byp_found) begin
      upd_valid_o = 1'b1;
      update_o    = byp_ent;
      if (upd_ready_i)
        push = elig & ~byp_sel;
    end
    fifo_pop = (count != '0) && upd_ready_i;
`else
    fifo_pop = upd_valid_o && upd_ready_i;
`endif
    push_cnt = '0;
    widx     = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      widx[c] = tail + AW'(push_cnt);
      if (push[c])
        push_cnt = push_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      mem              <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (push[c])
          mem[widx[c]] <= ent[c];
      end
      head             <= head + AW'(fifo_pop);
      tail             <= tail + AW'(push_cnt);
      count            <= count + push_cnt - CW'(fifo_pop);
      redirect_valid_o <= any_mp;
      if (any_mp)
        redirect_pc_o <= redir_tgt;
    end
  end

endmodule

// File: doc/bpf_queue.md
# bpf_queue

Multi-channel branch-resolution feedback unit. It sits between the execute-stage branch units and the BPU. It resolves up to NCH branches per cycle (channel 0 = oldest), computes target/taken/mispredict and picks the oldest mispredict to drive a registered front-end redirect. Resolved-branch updates are buffered in a DEPTH-entry FIFO and drained one per cycle to the BPU through a valid/ready handshake.

## Interface
Parameters:
- NCH, 2, resolve channels per cycle (1..4)
- DEPTH, 8, update FIFO entries; power of two, ≥ NCH

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- flush_i  input  1  backend flush (exception/ertn); drops this cycle's inputs
- in_valid_i  input  [NCH]  channel holds a branch-unit instruction
- in_ready_o  output  1  all NCH channels may be accepted this cycle
- pc_i / rj_i / rd_i  input  [NCH][32]  pc and operands
- decode_i  input  decode_info_t[NCH]  uses general.inst25_0, ex.cmp_type, ex.branch_link
- br_type_i  input  branch_type_t[NCH]  INVALID/IMMEDIATE/INDIRECT/CONDITION
- predict_i  input  bpu_predict_t[NCH]  npc, lphr, lphr_index carried from fetch
- redirect_valid_o  output  1  front-end redirect pulse
- redirect_pc_o  output  32  corrected fetch pc
- upd_valid_o  output  1  head entry valid
- upd_ready_i  input  1  BPU accepts head entry
- update_o  output  bpu_update_t  head entry

## Operation
- Per channel, the target is computed combinationally:
  - IMMEDIATE: pc + (sext(offs26) << 2)
  - INDIRECT: rj + (sext(inst[25:10]) << 2)
  - CONDITION: pc + (sext(inst[25:10]) << 2)
  - otherwise: pc + 4
  - All arithmetic is mod 2^32.
- taken:
  - CONDITION uses cmp_type: EQL ==, NEQ !=, LSS/GER/LEQ/GEQ signed <, >, <=, >=, LTU unsigned <, GEU unsigned >=. Any other cmp_type gives 0.
  - Other non-INVALID types give 1. INVALID gives 0.
- mispredict[c] = accept && in_valid_i[c] && br_type_i[c] != INVALID && predict_i[c].npc != target[c][31:2].
- accept = |in_valid_i && in_ready_o && !flush_i.
- Let k be the lowest channel with a mispredict. Channels above k are squashed: not enqueued, no redirect.
- Enqueue valid, non-INVALID, unsquashed channels in channel order at tail. Push count p ranges 0..NCH.
- update_o fields:
  - flush = btb_update = mispredict
  - br_taken = taken
  - pc = pc[31:2]
  - br_target = target[31:2]
  - bht_update = lpht_update = 1
  - lphr and lphr_index pass through from predict_i
- br_type classification, in priority order:
  - CALL: (INDIRECT && rd_idx == 1) || branch_link
  - RETURN: INDIRECT && rj_idx == 1 && offs16 == 0
  - ABSOLUTE: IMMEDIATE or INDIRECT
  - PC_RELATIVE: all others
- FIFO:
  - head/tail pointers wrap mod DEPTH; count holds 0..DEPTH.
  - Pop occurs when upd_valid_o && upd_ready_i.
  - Each cycle: count_next = count + p − pop. Push and pop in the same cycle are allowed, including at full or empty.
- in_ready_o = (DEPTH − count) ≥ NCH. It depends on registered count only, never on in_valid_i.
- With in_valid_i high and in_ready_o low, nothing is accepted. The producer holds its inputs.
- flush_i: the cycle's inputs are discarded. FIFO contents are kept and continue draining. A redirect already registered still fires.

## Timing
- Reset values:
  - redirect_valid_o = 0, redirect_pc_o = 0
  - upd_valid_o = 0, update_o = 0
  - count = 0, pointers = 0
  - in_ready_o = 1
- Redirect: mispredict accepted in cycle t gives redirect_valid_o = 1 and redirect_pc_o = target[k] in t+1, for one cycle only.
- Update latency: an entry accepted in t is at the head at earliest in t+1. The FIFO head is the registered output.
- upd_valid_o = (count != 0). update_o is stable while upd_valid_o && !upd_ready_i.
- Reset asserted mid-operation clears the FIFO and the pending redirect immediately.

## Configuration
- BPF_BYPASS_EN defined:
  - When count == 0, the lowest enqueue-eligible channel of the current accept drives upd_valid_o/update_o combinationally.
  - If upd_ready_i is high, that entry is consumed in the same cycle and not written to the FIFO. The remaining channels are pushed. Latency is 0.
- BPF_BYPASS_EN undefined: the head is FIFO output only; minimum latency is 1 cycle.

## Test plan
- Reset, then idle: redirect_valid_o=0, upd_valid_o=0, in_ready_o=1.
- NCH=2. ch0 BEQ pc=0x1000, rj=rd=5, offs16=4, npc=0x1010>>2; ch1 B pc=0x1004. Expect: no redirect, two entries pop in order: br_target 0x404, then 0x1004+imm.
- ch0 BLTU rj=1, rd=0xFFFFFFFF, predicted not taken (npc=0x1004>>2). Expect: redirect at t+1 to pc+offs. ch1 squashed (one entry only, flush=1, btb_update=1).
- GEU rj=rd=7: taken=1. JIRL rd=1 gives CALL. JIRL rj=1, rd=0, offs16=0 gives RETURN.
- Hold upd_ready_i=0 and fill to DEPTH−1. Expect in_ready_o=0 and a held input not accepted. Raise upd_ready_i: expect in_ready_o=1 once count ≤ DEPTH−NCH. Pointers wrap and order is preserved.
- flush_i high with a mispredicting input: no redirect, no push. Existing entries still drain. With BPF_BYPASS_EN, an empty FIFO plus upd_ready_i=1 presents the accepted entry in the same cycle.
